// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: clips an axis-aligned rectangle to the visible area and
// streams one framebuffer write per pixel in row-major order, with backpressure.
module fb_rect_fill #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COORD_BITS = 10,
  parameter int ADDR_BITS  = 19,
  parameter int PIXEL_BITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [COORD_BITS-1:0] cmd_x0,
  input  logic [COORD_BITS-1:0] cmd_y0,
  input  logic [COORD_BITS-1:0] cmd_x1,
  input  logic [COORD_BITS-1:0] cmd_y1,
  input  logic [PIXEL_BITS-1:0] cmd_color,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ADDR_BITS-1:0]  fb_write_addr,
  output logic [PIXEL_BITS-1:0] fb_write_data,
  output logic                  fb_write_en,
  input  logic                  fb_write_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [COORD_BITS-1:0] X_MAX  = COORD_BITS'(H_RES - 1);
  localparam logic [COORD_BITS-1:0] Y_MAX  = COORD_BITS'(V_RES - 1);
  localparam logic [ADDR_BITS-1:0]  STRIDE = ADDR_BITS'(H_RES);

  logic [1:0]            state_q, state_d;
  logic [COORD_BITS-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_BITS-1:0] x_q, x_d, y_q, y_d;
  logic [PIXEL_BITS-1:0] color_q, color_d;
  logic [ADDR_BITS-1:0]  row_base_q, row_base_d;
  logic [COORD_BITS-1:0] x0c, y0c, x1c, y1c;

  assign x0c = (x0_q > X_MAX) ? X_MAX : x0_q;
  assign x1c = (x1_q > X_MAX) ? X_MAX : x1_q;
  assign y0c = (y0_q > Y_MAX) ? Y_MAX : y0_q;
  assign y1c = (y1_q > Y_MAX) ? Y_MAX : y1_q;

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    x_d        = x_q;
    y_d        = y_q;
    color_d    = color_q;
    row_base_d = row_base_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          x1_d    = cmd_x1;
          y1_d    = cmd_y1;
          color_d = cmd_color;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // Corners are replaced by their clipped values so WRITE compares against them directly.
        x0_d = x0c;
        y0_d = y0c;
        x1_d = x1c;
        y1_d = y1c;
        if ((x0c > x1c) || (y0c > y1c)) begin
          state_d = S_DONE;
        end else begin
          row_base_d = ADDR_BITS'(y0c) * STRIDE;
          x_d        = x0c;
          y_d        = y0c;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (fb_write_ready) begin
          if ((x_q == x1_q) && (y_q == y1_q)) begin
            state_d = S_DONE;
          end else if (x_q < x1_q) begin
            x_d = x_q + 1'b1;
          end else begin
            x_d        = x0_q;
            y_d        = y_q + 1'b1;
            row_base_d = row_base_q + STRIDE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
      row_base_q <= row_base_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign fb_write_en   = (state_q == S_WRITE);
  assign fb_write_addr = row_base_q + ADDR_BITS'(x_q);
  assign fb_write_data = color_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: a table of rectangle commands plus hand-written
// backpressure, ignored-command and mid-operation reset sequences, checked via a write scoreboard.
module tb_fb_rect_fill;

  logic        clock;
  logic        reset;
  logic [9:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [2:0]  cmd_color;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [18:0] fb_write_addr;
  logic [2:0]  fb_write_data;
  logic        fb_write_en;
  logic        fb_write_ready;
  logic        busy;
  logic        done;

  fb_rect_fill dut (
    .clock(clock), .reset(reset),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
    .fb_write_en(fb_write_en), .fb_write_ready(fb_write_ready),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  typedef struct {
    int x0, y0, x1, y1, col;
    int n, first, last;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   sb_on = 1'b1;
  int   wr_cnt, first_addr, last_addr, first_cyc, done_cnt, done_cyc;
  bit   prev_stall = 1'b0;
  int   prev_addr, prev_data;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every accepted write is popped against the scoreboard; stalled writes must hold.
  always @(negedge clock) begin
    if (!reset && sb_on) begin
      if (prev_stall) begin
        chk("hold_en", fb_write_en, 1);
        chk("hold_addr", fb_write_addr, prev_addr);
        chk("hold_data", fb_write_data, prev_data);
      end
      if (fb_write_en && fb_write_ready) begin
        if (wr_cnt == 0) begin
          first_addr = fb_write_addr;
          first_cyc  = cyc;
        end
        last_addr = fb_write_addr;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_extra_write: got addr %0d, expected no write", fb_write_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_addr", fb_write_addr, e.addr);
          chk("sb_data", fb_write_data, e.data);
        end
      end
    end
    prev_stall = fb_write_en && !fb_write_ready;
    prev_addr  = fb_write_addr;
    prev_data  = fb_write_data;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic model_push(input int x0, input int y0, input int x1, input int y1, input int col);
    int cx0, cy0, cx1, cy1;
    exp_t e;
    cx0 = (x0 > 639) ? 639 : x0;
    cx1 = (x1 > 639) ? 639 : x1;
    cy0 = (y0 > 479) ? 479 : y0;
    cy1 = (y1 > 479) ? 479 : y1;
    for (int y = cy0; y <= cy1; y++) begin
      for (int x = cx0; x <= cx1; x++) begin
        e.addr = y * 640 + x;
        e.data = col;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic begin_cmd();
    wr_cnt   = 0;
    done_cnt = 0;
    done_cyc = -1000;
  endtask

  // Returns in cycle acc+1 (just after the accepting edge), with cmd_valid dropped.
  task automatic send(input int x0, input int y0, input int x1, input int y1,
                      input int col, output int acc);
    int g;
    g = 0;
    @(negedge clock); #1;
    while (!cmd_ready && g < 100) begin
      @(negedge clock); #1;
      g++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_x0    = 10'(x0);
    cmd_y0    = 10'(y0);
    cmd_x1    = 10'(x1);
    cmd_y1    = 10'(y1);
    cmd_color = 3'(col);
    cmd_valid = 1'b1;
    acc = cyc;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 2000) begin
      @(negedge clock); #1;
      t++;
    end
    if (done_cnt == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done, expected done within 2000 cycles");
    end else begin
      chk("busy_at_done", busy, 1);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(negedge clock); #1;
    end
  endtask

  task automatic check_end(input int acc, input int n);
    chk("n_writes", wr_cnt, n);
    chk("done_cycle", done_cyc - acc, n + 2);
    chk("done_pulses", done_cnt, 1);
    chk("sb_left", exp_q.size(), 0);
    wait_cyc(acc + n + 3);
    chk("ready_after", cmd_ready, 1);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    begin_cmd();
    model_push(v.x0, v.y0, v.x1, v.y1, v.col);
    send(v.x0, v.y0, v.x1, v.y1, v.col, acc);
    @(negedge clock); #1;
    chk("busy_setup", busy, 1);
    chk("ready_setup", cmd_ready, 0);
    wait_done();
    if (v.n > 0) begin
      chk("first_addr", first_addr, v.first);
      chk("last_addr", last_addr, v.last);
      chk("first_cycle", first_cyc - acc, 2);
    end
    check_end(acc, v.n);
    $display("cmd (%0d,%0d)-(%0d,%0d) color %0d: %0d writes, done at +%0d",
             v.x0, v.y0, v.x1, v.y1, v.col, wr_cnt, done_cyc - acc);
  endtask

  vec_t vecs[7];

  initial begin
    int acc;
    int pat[7];
    int pres[7];
    int dcnt;

    vecs[0] = '{x0:5,   y0:7,   x1:5,    y1:7,    col:5, n:1,   first:4485,   last:4485};
    vecs[1] = '{x0:638, y0:0,   x1:639,  y1:1,    col:2, n:4,   first:638,    last:1279};
    vecs[2] = '{x0:630, y0:470, x1:700,  y1:500,  col:7, n:100, first:301430, last:307199};
    vecs[3] = '{x0:10,  y0:5,   x1:3,    y1:5,    col:1, n:0,   first:0,      last:0};
    vecs[4] = '{x0:0,   y0:0,   x1:3,    y1:2,    col:6, n:12,  first:0,      last:1283};
    vecs[5] = '{x0:700, y0:0,   x1:800,  y1:10,   col:3, n:11,  first:639,    last:7039};
    vecs[6] = '{x0:0,   y0:479, x1:1023, y1:1023, col:4, n:640, first:306560, last:307199};
    pat  = '{1, 0, 0, 1, 0, 1, 1};
    pres = '{0, 1, 1, 1, 2, 2, 3};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    fb_write_ready = 1'b1;
    begin_cmd();
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_en", fb_write_en, 0);
    chk("rst_wr_addr", fb_write_addr, 0);
    chk("rst_wr_data", fb_write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: ready pattern applied from the first WRITE cycle.
    begin_cmd();
    model_push(0, 0, 3, 0, 4);
    send(0, 0, 3, 0, 4, acc);
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      fb_write_ready = pat[i][0];
      @(negedge clock); #1;
      chk("bp_en", fb_write_en, 1);
      chk("bp_addr", fb_write_addr, pres[i]);
    end
    @(posedge clock); #1;
    fb_write_ready = 1'b1;
    wait_done();
    chk("bp_done_cycle", done_cyc - acc, 9);
    chk("bp_writes", wr_cnt, 4);
    chk("bp_sb_left", exp_q.size(), 0);
    $display("backpressure (0,0)-(3,0): %0d writes, done at +%0d", wr_cnt, done_cyc - acc);

    // A second command offered while busy must be neither acknowledged nor executed.
    begin_cmd();
    model_push(0, 1, 4, 1, 2);
    send(0, 1, 4, 1, 2, acc);
    cmd_x0 = 10'd100; cmd_y0 = 10'd100; cmd_x1 = 10'd100; cmd_y1 = 10'd100; cmd_color = 3'd7;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      chk("ignored_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    wait_done();
    check_end(acc, 5);
    $display("ignored-cmd (0,1)-(4,1): %0d writes, done at +%0d", wr_cnt, done_cyc - acc);

    // Reset asserted during the 3rd write of a 10-pixel row.
    sb_on = 1'b0;
    begin_cmd();
    send(0, 0, 9, 0, 1, acc);
    repeat (3) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(negedge clock); #1;
    chk("rst_mid_addr", fb_write_addr, 2);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #1;
    chk("rst_mid_en", fb_write_en, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_busy", busy, 0);
    repeat (3) begin
      @(negedge clock); #1;
    end
    dcnt = done_cnt;
    chk("rst_mid_no_done", dcnt, 0);
    $display("reset mid-operation of (0,0)-(9,0): done pulses %0d", dcnt);
    exp_q.delete();
    sb_on = 1'b1;
    run_vec('{x0:2, y0:2, x1:2, y1:2, col:6, n:1, first:1282, last:1282});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
